// File: rtl/approx_sweep_pkg.sv
// Shared types and width helpers for the approximate-multiplier sweep engine.
package approx_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_ROW  = 1'b1;

  // Pair counter must reach 2^(2N) itself, hence one bit beyond 2N.
  function automatic int cnt_width(input int n);
    return 2 * n + 1;
  endfunction

  // Sum of up to 2^(2N) errors, each below 2^(2N).
  function automatic int sum_width(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/approx_sweep_delay.sv
// Valid/payload shift register that lines issued operands up with a pipelined DUT.
module approx_sweep_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = clk ^ rst_n;
    assign out_vld     = in_vld;
    assign out_data    = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];

    always_comb begin
      vld_d[0]  = in_vld;
      data_d[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end

    // Clearing the valid bits is what discards in-flight pairs on reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];
  end

endmodule

// File: rtl/approx_mul_sweep_engine.sv
// Exhaustive sweep harness: drives every operand pair into an external
// approximate multiplier and accumulates error metrics against the exact product.
module approx_mul_sweep_engine
  import approx_sweep_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int DUT_LAT = 0,
  localparam int P_FULL  = 2 ** (2 * N),
  localparam int CNT_W   = cnt_width(N),
  localparam int SUM_W   = sum_width(N),
  localparam int PROD_W  = 2 * N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [N-1:0]      row_a,
  output logic [N-1:0]      dut_a,
  output logic [N-1:0]      dut_b,
  input  logic [PROD_W-1:0] dut_prod,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [SUM_W-1:0]  sum_abs_err,
  output logic [PROD_W-1:0] max_abs_err,
  output logic [N-1:0]      first_err_a,
  output logic [N-1:0]      first_err_b,
  output logic              first_err_vld
);

  localparam int               DRN_W    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] P_FULL_C = CNT_W'(P_FULL);
  localparam logic [CNT_W-1:0] P_ROW_C  = CNT_W'(2 ** N);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [DRN_W-1:0]    drn_q, drn_d;
  logic                mode_q, mode_d;
  logic [N-1:0]        row_a_q, row_a_d;
  logic [N-1:0]        a_q, a_d, b_q, b_d;
  logic                iss_vld_q, iss_vld_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [PROD_W-1:0]   max_q, max_d;
  logic [N-1:0]        fa_q, fa_d, fb_q, fb_d;
  logic                fv_q, fv_d;

  logic [CNT_W-1:0]    p_count;
  logic                cmp_vld;
  logic [2*N-1:0]      cmp_ab;
  logic [N-1:0]        cmp_a, cmp_b;
  logic [PROD_W-1:0]   exact, abs_diff;
  logic [PROD_W:0]     diff;
  logic                mismatch;

  approx_sweep_delay #(
    .W     (2 * N),
    .DEPTH (DUT_LAT)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (iss_vld_q),
    .in_data  ({a_q, b_q}),
    .out_vld  (cmp_vld),
    .out_data (cmp_ab)
  );

  // One extra sign bit makes the subtraction safe before taking magnitude.
  always_comb begin
    cmp_a    = cmp_ab[2*N-1:N];
    cmp_b    = cmp_ab[N-1:0];
    exact    = PROD_W'(cmp_a) * PROD_W'(cmp_b);
    diff     = {1'b0, exact} - {1'b0, dut_prod};
    abs_diff = diff[PROD_W] ? PROD_W'(-diff) : diff[PROD_W-1:0];
    mismatch = cmp_vld && (exact != dut_prod);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drn_d       = drn_q;
    mode_d      = mode_q;
    row_a_d     = row_a_q;
    a_d         = a_q;
    b_d         = b_q;
    iss_vld_d   = 1'b0;
    err_count_d = err_count_q;
    sum_d       = sum_q;
    max_d       = max_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    fv_d        = fv_q;
    p_count     = (mode_q == MODE_ROW) ? P_ROW_C : P_FULL_C;

    // Accumulation follows the delay line, independent of FSM state.
    if (mismatch) begin
      err_count_d = err_count_q + CNT_W'(1);
      sum_d       = sum_q + SUM_W'(abs_diff);
      if (abs_diff > max_q) max_d = abs_diff;
      if (!fv_q) begin
        fa_d = cmp_a;
        fb_d = cmp_b;
        fv_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          idx_d       = '0;
          mode_d      = mode;
          row_a_d     = row_a;
          err_count_d = '0;
          sum_d       = '0;
          max_d       = '0;
          fa_d        = '0;
          fb_d        = '0;
          fv_d        = 1'b0;
        end
      end
      RUN: begin
        if (idx_q != p_count) begin
          a_d       = (mode_q == MODE_ROW) ? row_a_q : idx_q[2*N-1:N];
          b_d       = idx_q[N-1:0];
          idx_d     = idx_q + CNT_W'(1);
          iss_vld_d = 1'b1;
        end else if (DUT_LAT == 0) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
          drn_d   = '0;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) state_d = DONE;
        else drn_d = drn_q + DRN_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      drn_q       <= '0;
      mode_q      <= 1'b0;
      row_a_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      iss_vld_q   <= 1'b0;
      err_count_q <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      fa_q        <= '0;
      fb_q        <= '0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drn_q       <= drn_d;
      mode_q      <= mode_d;
      row_a_q     <= row_a_d;
      a_q         <= a_d;
      b_q         <= b_d;
      iss_vld_q   <= iss_vld_d;
      err_count_q <= err_count_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      fv_q        <= fv_d;
    end
  end

  assign dut_a         = a_q;
  assign dut_b         = b_q;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign err_count     = err_count_q;
  assign sum_abs_err   = sum_q;
  assign max_abs_err   = max_q;
  assign first_err_a   = fa_q;
  assign first_err_b   = fb_q;
  assign first_err_vld = fv_q;

endmodule

// File: tb/tb_approx_mul_sweep_engine.sv
// Bench for approx_mul_sweep_engine: a combinational and a 2-stage DUT model,
// each attached to its own engine instance, checked against a sweep-level reference.
module tb_approx_mul_sweep_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] row_a = 4'd0;

  int dut_kind = 0;
  int rkey = 0;
  int n_vec = 0;
  int n_mis = 0;

  logic [3:0]  a0, b0, fa0, fb0, a2, b2, fa2, fb2;
  logic [7:0]  prod0, prod2, mx0, mx2, p2_s1, p2_s2;
  logic        busy0, done0, fv0, busy2, done2, fv2;
  logic [8:0]  ec0, ec2;
  logic [15:0] sum0, sum2;
  logic [63:0] met0, met2, all0, all2;

  int done_e0, done_e2, busy_lo_e0, busy_lo_e2;
  logic busy_at0_0, busy_at0_2;

  localparam logic [63:0] EXP_ZERO = 64'd0;
  localparam logic [63:0] EXP_LSB  = {22'd0, 9'd64, 16'd64, 8'd1, 4'd1, 4'd1, 1'b1};
  localparam logic [63:0] EXP_ROW  = {22'd0, 9'd12, 16'd24, 8'd3, 4'd15, 4'd1, 1'b1};

  always #5 clk = ~clk;

  // Behavioural multipliers under test; kind 3 is a keyed pseudo-random corruption.
  function automatic logic [7:0] approx(input int kind, input int a, input int b);
    int ex;
    ex = a * b;
    case (kind)
      1: return 8'(ex & ~1);
      2: return 8'(ex & ~3);
      3: begin
        if (((a * 7 + b * 3 + rkey) % 5) == 0) return 8'(ex ^ ((rkey % 31) + 1));
        return 8'(ex);
      end
      default: return 8'(ex);
    endcase
  endfunction

  function automatic logic [63:0] model(input int kind, input logic m, input logic [3:0] ra);
    int errs, sum, mx, fa, fb, np, a, b, ex, got, d;
    bit fv;
    errs = 0; sum = 0; mx = 0; fa = 0; fb = 0; fv = 1'b0;
    np = m ? 16 : 256;
    for (int i = 0; i < np; i++) begin
      a   = m ? int'(ra) : i / 16;
      b   = i % 16;
      ex  = a * b;
      got = int'(approx(kind, a, b));
      d   = (ex > got) ? ex - got : got - ex;
      if (d != 0) begin
        errs++;
        sum += d;
        if (d > mx) mx = d;
        if (!fv) begin fv = 1'b1; fa = a; fb = b; end
      end
    end
    return {22'd0, 9'(errs), 16'(sum), 8'(mx), 4'(fa), 4'(fb), fv};
  endfunction

  always_comb prod0 = approx(dut_kind, int'(a0), int'(b0));

  always @(posedge clk) begin
    p2_s1 <= approx(dut_kind, int'(a2), int'(b2));
    p2_s2 <= p2_s1;
  end
  assign prod2 = p2_s2;

  assign met0 = {22'd0, ec0, sum0, mx0, fa0, fb0, fv0};
  assign met2 = {22'd0, ec2, sum2, mx2, fa2, fb2, fv2};
  assign all0 = {12'd0, met0[41:0], a0, b0, busy0, done0};
  assign all2 = {12'd0, met2[41:0], a2, b2, busy2, done2};

  approx_mul_sweep_engine #(.N(4), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .row_a(row_a),
    .dut_a(a0), .dut_b(b0), .dut_prod(prod0), .busy(busy0), .done(done0),
    .err_count(ec0), .sum_abs_err(sum0), .max_abs_err(mx0),
    .first_err_a(fa0), .first_err_b(fb0), .first_err_vld(fv0)
  );

  approx_mul_sweep_engine #(.N(4), .DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .row_a(row_a),
    .dut_a(a2), .dut_b(b2), .dut_prod(prod2), .busy(busy2), .done(done2),
    .err_count(ec2), .sum_abs_err(sum2), .max_abs_err(mx2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_vld(fv2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep (edge 0) and record the edge numbers where done rises and busy falls.
  task automatic do_sweep(input int kind, input logic m, input logic [3:0] ra, input int poke_at);
    int np;
    np = m ? 16 : 256;
    dut_kind = kind;
    mode = m;
    row_a = ra;
    start = 1'b1;
    step();
    start = 1'b0;
    busy_at0_0 = busy0;
    busy_at0_2 = busy2;
    done_e0 = -1; done_e2 = -1; busy_lo_e0 = -1; busy_lo_e2 = -1;
    for (int k = 1; k <= np + 20; k++) begin
      if (k == poke_at) start = 1'b1;
      step();
      start = 1'b0;
      if (done0 && done_e0 < 0) done_e0 = k;
      if (done2 && done_e2 < 0) done_e2 = k;
      if (!busy0 && busy_lo_e0 < 0) busy_lo_e0 = k;
      if (!busy2 && busy_lo_e2 < 0) busy_lo_e2 = k;
      if (done_e0 >= 0 && done_e2 >= 0 && busy_lo_e2 >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_vec++;
    if (all0 !== EXP_ZERO) begin n_mis++; $display("[TB] FAIL reset_outputs_lat0: got %h expected %h", all0, EXP_ZERO); end
    n_vec++;
    if (all2 !== EXP_ZERO) begin n_mis++; $display("[TB] FAIL reset_outputs_lat2: got %h expected %h", all2, EXP_ZERO); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_exact();
    do_sweep(0, 1'b0, 4'd0, -1);
    n_vec++;
    if (done_e0 != 257) begin n_mis++; $display("[TB] FAIL exact_done_edge_lat0: got %0d expected 257", done_e0); end
    n_vec++;
    if (done_e2 != 259) begin n_mis++; $display("[TB] FAIL exact_done_edge_lat2: got %0d expected 259", done_e2); end
    n_vec++;
    if (met0 !== EXP_ZERO) begin n_mis++; $display("[TB] FAIL exact_metrics_lat0: got %h expected %h", met0, EXP_ZERO); end
    n_vec++;
    if (met2 !== EXP_ZERO) begin n_mis++; $display("[TB] FAIL exact_metrics_lat2: got %h expected %h", met2, EXP_ZERO); end
    for (int k = 0; k < 5; k++) step();
    n_vec++;
    if ({done0, done2, a0, b0, a2, b2} !== {2'b11, 16'hFFFF}) begin
      n_mis++; $display("[TB] FAIL exact_hold_done: got %h expected %h", {done0, done2, a0, b0, a2, b2}, {2'b11, 16'hFFFF});
    end
  endtask

  task automatic test_lsb_drop();
    do_sweep(1, 1'b0, 4'd0, -1);
    n_vec++;
    if (met0 !== EXP_LSB) begin n_mis++; $display("[TB] FAIL lsb_metrics_lat0: got %h expected %h", met0, EXP_LSB); end
    n_vec++;
    if (met2 !== EXP_LSB) begin n_mis++; $display("[TB] FAIL lsb_metrics_lat2: got %h expected %h", met2, EXP_LSB); end
    n_vec++;
    if ({done_e0, done_e2} != {32'd257, 32'd259}) begin
      n_mis++; $display("[TB] FAIL lsb_done_edges: got %0d/%0d expected 257/259", done_e0, done_e2);
    end
    n_vec++;
    if ({busy_at0_0, busy_at0_2} !== 2'b11) begin n_mis++; $display("[TB] FAIL lsb_busy_edge0: got %b expected 11", {busy_at0_0, busy_at0_2}); end
    n_vec++;
    if ({busy_lo_e0, busy_lo_e2} != {32'd257, 32'd259}) begin
      n_mis++; $display("[TB] FAIL lsb_busy_fall: got %0d/%0d expected 257/259", busy_lo_e0, busy_lo_e2);
    end
  endtask

  task automatic test_row();
    do_sweep(2, 1'b1, 4'd15, -1);
    n_vec++;
    if (met0 !== EXP_ROW) begin n_mis++; $display("[TB] FAIL row_metrics_lat0: got %h expected %h", met0, EXP_ROW); end
    n_vec++;
    if (met2 !== EXP_ROW) begin n_mis++; $display("[TB] FAIL row_metrics_lat2: got %h expected %h", met2, EXP_ROW); end
    n_vec++;
    if ({done_e0, done_e2} != {32'd17, 32'd19}) begin
      n_mis++; $display("[TB] FAIL row_done_edges: got %0d/%0d expected 17/19", done_e0, done_e2);
    end
  endtask

  task automatic test_reset_abort();
    dut_kind = 1;
    mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 101; k++) step();
    n_vec++;
    if ({a0, b0} !== 8'd100) begin n_mis++; $display("[TB] FAIL abort_pair100_issued: got %0d expected 100", {a0, b0}); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_vec++;
    if (all0 !== EXP_ZERO) begin n_mis++; $display("[TB] FAIL abort_outputs_lat0: got %h expected %h", all0, EXP_ZERO); end
    n_vec++;
    if (all2 !== EXP_ZERO) begin n_mis++; $display("[TB] FAIL abort_outputs_lat2: got %h expected %h", all2, EXP_ZERO); end
    for (int k = 0; k < 6; k++) step();
    n_vec++;
    if ({all0, all2} !== {EXP_ZERO, EXP_ZERO}) begin
      n_mis++; $display("[TB] FAIL abort_quiet: got %h/%h expected zero", all0, all2);
    end
    do_sweep(0, 1'b0, 4'd0, -1);
    n_vec++;
    if (done_e0 != 257) begin n_mis++; $display("[TB] FAIL abort_rerun_done: got %0d expected 257", done_e0); end
    n_vec++;
    if ({met0, met2} !== {EXP_ZERO, EXP_ZERO}) begin
      n_mis++; $display("[TB] FAIL abort_rerun_metrics: got %h/%h expected zero", met0, met2);
    end
  endtask

  task automatic test_restart_ignored();
    do_sweep(1, 1'b0, 4'd0, 52);
    n_vec++;
    if ({done_e0, done_e2} != {32'd257, 32'd259}) begin
      n_mis++; $display("[TB] FAIL restart_done_edges: got %0d/%0d expected 257/259", done_e0, done_e2);
    end
    n_vec++;
    if ({met0, met2} !== {EXP_LSB, EXP_LSB}) begin
      n_mis++; $display("[TB] FAIL restart_metrics: got %h/%h expected %h", met0, met2, EXP_LSB);
    end
  endtask

  // start sampled on the very edge where the combinational-DUT instance enters DONE.
  task automatic test_start_at_done_entry();
    do_sweep(2, 1'b0, 4'd0, 257);
    n_vec++;
    if ({done0, busy0} !== 2'b10) begin n_mis++; $display("[TB] FAIL done_entry_start_ignored: got %b expected 10", {done0, busy0}); end
    n_vec++;
    if (done_e2 != 259) begin n_mis++; $display("[TB] FAIL done_entry_lat2_edge: got %0d expected 259", done_e2); end
    n_vec++;
    if (met0 !== model(2, 1'b0, 4'd0)) begin
      n_mis++; $display("[TB] FAIL done_entry_metrics: got %h expected %h", met0, model(2, 1'b0, 4'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ra;
    logic [63:0] exp;
    ra = 4'($urandom_range(1, 15));
    rkey = int'($urandom_range(0, 1000));
    exp = model(3, 1'b1, ra);
    do_sweep(3, 1'b1, ra, -1);
    n_vec++;
    if ({met0, met2} !== {exp, exp}) begin n_mis++; $display("[TB] FAIL b2b_metrics: got %h/%h expected %h", met0, met2, exp); end
    n_vec++;
    if ({done_e0, done_e2} != {32'd17, 32'd19}) begin
      n_mis++; $display("[TB] FAIL b2b_done_edges: got %0d/%0d expected 17/19", done_e0, done_e2);
    end
  endtask

  task automatic test_random();
    int kind, np;
    logic m;
    logic [3:0] ra;
    logic [63:0] exp;
    for (int it = 0; it < 5; it++) begin
      kind = int'($urandom_range(0, 3));
      m = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rkey = int'($urandom_range(0, 1000));
      np = m ? 16 : 256;
      exp = model(kind, m, ra);
      do_sweep(kind, m, ra, -1);
      n_vec++;
      if (met0 !== exp) begin n_mis++; $display("[TB] FAIL rand%0d_metrics_lat0: got %h expected %h", it, met0, exp); end
      n_vec++;
      if (met2 !== exp) begin n_mis++; $display("[TB] FAIL rand%0d_metrics_lat2: got %h expected %h", it, met2, exp); end
      n_vec++;
      if (done_e0 != np + 1 || done_e2 != np + 3) begin
        n_mis++; $display("[TB] FAIL rand%0d_done_edges: got %0d/%0d expected %0d/%0d", it, done_e0, done_e2, np + 1, np + 3);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_exact();
    test_lsb_drop();
    test_row();
    test_reset_abort();
    test_restart_ignored();
    test_start_at_done_entry();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
